host_copy_sequencer: RTL and testbench
======================================

# host_copy_sequencer

Sequencer that copies a block of cache lines from a source to a destination in host memory, one line at a time, through the single-request port of the memory controller. It issues a read for each line and holds the returned 512-bit line in a one-line buffer. It then writes that line back out and advances both addresses by 64 bytes. It sits between a requester (CPU start register or memory map) and the memory controller's op/address/data port, and owns that port for the whole duration of a job.

## Interface
- ADDR_WIDTH, 64: virtual byte address width.
- SIZE_WIDTH, 43: line-count width.
- DATA_WIDTH, 512: cache-line data width.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request.
- abort  in  1  stop after the current memory request.
- src_addr  in  ADDR_WIDTH  source byte address, sampled at start.
- dst_addr  in  ADDR_WIDTH  destination byte address, sampled at start.
- num_lines  in  SIZE_WIDTH  number of lines to copy, sampled at start.
- busy  out  1  job in progress.
- done  out  1  job finished; level signal, cleared by the next accepted start.
- lines_done  out  SIZE_WIDTH  lines fully written in the current or last job.
- op  out  2  memory op: 2'b00 none, 2'b01 read, 2'b10 write.
- raw_address  out  ADDR_WIDTH  address of the current request.
- wr_data  out  DATA_WIDTH  buffered line driven during writes.
- rd_data  in  DATA_WIDTH  line returned by the controller.
- rd_valid  in  1  rd_data valid this cycle.
- tx_done  in  1  current request complete.
- perf_cycles  out  32  present only with XFER_PERF_CNT_EN.

## Operation
- States: IDLE, READ, RGAP, WRITE, WGAP, DONE.
- **Start acceptance**
  - start is accepted only in IDLE or DONE; it is ignored otherwise.
  - On acceptance:
    - src_ptr = src_addr with bits [5:0] forced to 0; dst_ptr = dst_addr with bits [5:0] forced to 0.
    - remaining = num_lines; lines_done = 0; done = 0.
  - If num_lines == 0 the next state is DONE; otherwise the next state is READ.
- **READ**
  - op = 01, raw_address = src_ptr.
  - On rd_valid, the line buffer captures rd_data. The capture happens even if rd_valid and tx_done arrive together.
  - On tx_done the next state is RGAP.
- **RGAP**: op = 00 for exactly one cycle, then WRITE.
- **WRITE**
  - op = 10, raw_address = dst_ptr, wr_data = buffer.
  - On tx_done:
    - src_ptr += 64, dst_ptr += 64, remaining -= 1, lines_done += 1.
    - Next state is WGAP.
- **WGAP**: op = 00 for one cycle, then READ if remaining != 0, else DONE.
- **DONE**: done = 1; the block stays here until an accepted start.
- busy = 1 in READ, RGAP, WRITE and WGAP.
- **Abort**
  - abort is latched while busy. It takes effect only at the next RGAP or WGAP: the next state becomes DONE.
  - An aborted line leaves its read complete but no write. lines_done counts only written lines.
  - abort in IDLE or DONE is ignored. If start and abort arrive in the same cycle in IDLE, start is accepted and abort is ignored.
- **Address arithmetic**: pointers wrap modulo 2^ADDR_WIDTH and no error is flagged.
- **Hold rules**
  - op, raw_address and wr_data are registered. They stay stable throughout a request until tx_done.
  - tx_done or rd_valid outside READ/WRITE is ignored.

## Timing
- Reset values:
  - op = 00, raw_address = 0, wr_data = 0.
  - busy = 0, done = 0, lines_done = 0, perf_cycles = 0.
  - State is IDLE and the latched abort is cleared.
- rst overrides everything, including mid-request. The memory controller must be reset together with this block.
- Request timing:
  - The first op = 01 appears the cycle after start is accepted.
  - The next op is asserted the cycle after the gap cycle.
- Per-line minimum is 4 cycles, when tx_done arrives in the first cycle of each request.
- lines_done updates on the edge after the write's tx_done. done rises two edges after the last write's tx_done (via WGAP).
- A zero-length job shows done = 1 on the second cycle after start (IDLE→DONE) and never drives op.

## Configuration
- XFER_PERF_CNT_EN defined:
  - perf_cycles counts cycles while busy and saturates at 32'hFFFF_FFFF.
  - It clears on an accepted start and holds its value in DONE.
- XFER_PERF_CNT_EN undefined: the perf_cycles port and its counter are absent.

## Test plan
- **Single-line copy**
  - Stimulus: src = 0x1000, dst = 0x2000, n = 1; tx_done one cycle after each op; rd_data = 512'hA5...
  - Required response: op sequence 01,00,10,00; the write carries A5...; done = 1 and lines_done = 1.
- **Unaligned addresses**
  - Stimulus: src = 0x1013, dst = 0x2027, n = 3.
  - Required response: reads at 0x1000, 0x1040, 0x1080; writes at 0x2000, 0x2040, 0x2080.
- **Zero length**
  - Stimulus: n = 0.
  - Required response: op stays 00, done = 1 two cycles after start, lines_done = 0.
- **Abort**
  - Stimulus: n = 8; abort during the READ of line 3 (0-based).
  - Required response: that read completes, no write follows it, done = 1, lines_done = 3.
- **Start while busy**
  - Stimulus: a second start with n = 5 during an n = 4 job.
  - Required response: the second start is ignored and lines_done ends at 4.
- **Delayed completion and reset**
  - Stimulus: tx_done delayed 10 cycles with address and data held stable; with XFER_PERF_CNT_EN and n = 2, check perf_cycles; separately assert rst mid-WRITE.
  - Required response: address and data stay stable across the delay; perf_cycles = 48; after rst all outputs are at reset values.

Source files
------------

// File: rtl/host_copy_sequencer.sv
// Line-at-a-time host memory copy engine driving a single-request memory port.
// Optional cycle counter: define XFER_PERF_CNT_EN to add the perf_cycles port.
module host_copy_sequencer #(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 43,
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [SIZE_WIDTH-1:0] num_lines,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE_WIDTH-1:0] lines_done,
  output logic [1:0]            op,
  output logic [ADDR_WIDTH-1:0] raw_address,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  input  logic                  tx_done
`ifdef XFER_PERF_CNT_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // READ  | read request for src_ptr outstanding
  // RGAP  | one idle cycle between read and write
  // WRITE | write request of buffered line to dst_ptr outstanding
  // WGAP  | one idle cycle after a write, then next line or finish
  // DONE  | job finished or aborted, done held high
  typedef enum logic [2:0] {IDLE, READ, RGAP, WRITE, WGAP, DONE} state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(64);

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_ptr;
  logic [ADDR_WIDTH-1:0] dst_ptr;
  logic [SIZE_WIDTH-1:0] remaining;
  logic                  abort_q;
  logic                  accept;
  logic                  stop_now;
  logic [ADDR_WIDTH-1:0] src_aligned;
  logic [ADDR_WIDTH-1:0] dst_aligned;

  assign accept      = start && (state == IDLE || state == DONE);
  assign stop_now    = abort_q || abort;
  assign src_aligned = {src_addr[ADDR_WIDTH-1:6], 6'b0};
  assign dst_aligned = {dst_addr[ADDR_WIDTH-1:6], 6'b0};

  // wr_data doubles as the one-line buffer; it only changes on a read return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      remaining   <= '0;
      abort_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      lines_done  <= '0;
      op          <= OP_NONE;
      raw_address <= '0;
      wr_data     <= '0;
    end else begin
      if (busy && abort) abort_q <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            src_ptr    <= src_aligned;
            dst_ptr    <= dst_aligned;
            remaining  <= num_lines;
            lines_done <= '0;
            abort_q    <= 1'b0;
            if (num_lines == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= READ;
              busy        <= 1'b1;
              done        <= 1'b0;
              op          <= OP_RD;
              raw_address <= src_aligned;
            end
          end
        end
        READ: begin
          if (rd_valid) wr_data <= rd_data;
          if (tx_done) begin
            state <= RGAP;
            op    <= OP_NONE;
          end
        end
        RGAP: begin
          if (stop_now) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            abort_q <= 1'b0;
          end else begin
            state       <= WRITE;
            op          <= OP_WR;
            raw_address <= dst_ptr;
          end
        end
        WRITE: begin
          if (tx_done) begin
            state      <= WGAP;
            op         <= OP_NONE;
            src_ptr    <= src_ptr + LINE_BYTES;
            dst_ptr    <= dst_ptr + LINE_BYTES;
            remaining  <= remaining - SIZE_WIDTH'(1);
            lines_done <= lines_done + SIZE_WIDTH'(1);
          end
        end
        WGAP: begin
          if (stop_now || remaining == '0) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            abort_q <= 1'b0;
          end else begin
            state       <= READ;
            op          <= OP_RD;
            raw_address <= src_ptr;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          op    <= OP_NONE;
        end
      endcase
    end
  end

`ifdef XFER_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
    end else if (busy && perf_cycles != 32'hFFFF_FFFF) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_host_copy_sequencer.sv
// Directed bench for host_copy_sequencer with a simple latency-programmable memory responder.
module tb_host_copy_sequencer;
  localparam int AW = 64;
  localparam int SW = 43;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [SW-1:0] num_lines = '0;
  logic          busy, done;
  logic [SW-1:0] lines_done;
  logic [1:0]    op;
  logic [AW-1:0] raw_address;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data = '0;
  logic          rd_valid = 1'b0;
  logic          tx_done = 1'b0;
`ifdef XFER_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  host_copy_sequencer #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .num_lines(num_lines),
    .busy(busy), .done(done), .lines_done(lines_done),
    .op(op), .raw_address(raw_address), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .tx_done(tx_done)
`ifdef XFER_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  req_t          log_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            lat = 0;
  logic          use_pat = 1'b0;
  logic [DW-1:0] fixed_pat = '0;
  int            cnt = 0;
  int            stab_err = 0;
  logic [1:0]    ref_op;
  logic [AW-1:0] ref_addr;
  logic [DW-1:0] ref_data;

  // Memory controller model: completes each request after lat extra cycles.
  always @(negedge clk) begin
    req_t r;
    if (rst || op == 2'b00) begin
      cnt = 0; tx_done = 1'b0; rd_valid = 1'b0;
    end else begin
      if (cnt == 0) begin
        ref_op = op; ref_addr = raw_address; ref_data = wr_data;
      end else if (op !== ref_op || raw_address !== ref_addr || wr_data !== ref_data) begin
        stab_err++;
      end
      tx_done  = (cnt == lat);
      rd_valid = tx_done && (op == 2'b01);
      rd_data  = use_pat ? fixed_pat : {8{raw_address}};
      if (tx_done) begin
        r.op = op; r.addr = raw_address;
        r.data = (op == 2'b10) ? wr_data : rd_data;
        log_q.push_back(r);
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic start_job(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [SW-1:0] n);
    src_addr = s; dst_addr = d; num_lines = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (done) ok = 1; else tick();
    end
    vectors++;
    if (!ok) begin
      $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done, budget);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    vectors += 6;
    if (op !== 2'b00) begin $display("FAIL reset_op: got %b required 00", op); miscompares++; end
    if (raw_address !== '0) begin $display("FAIL reset_addr: got %h required 0", raw_address); miscompares++; end
    if (wr_data !== '0) begin $display("FAIL reset_wr_data: got %h required 0", wr_data); miscompares++; end
    if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b required 0", busy); miscompares++; end
    if (done !== 1'b0) begin $display("FAIL reset_done: got %b required 0", done); miscompares++; end
    if (lines_done !== '0) begin $display("FAIL reset_lines_done: got %0d required 0", lines_done); miscompares++; end
`ifdef XFER_PERF_CNT_EN
    vectors++;
    if (perf_cycles !== 32'd0) begin $display("FAIL reset_perf: got %0d required 0", perf_cycles); miscompares++; end
`endif
    rst = 1'b0; tick();
  endtask

  task automatic test_single_line();
    logic [1:0] exp_ops [4] = '{2'b01, 2'b00, 2'b10, 2'b00};
    lat = 0; use_pat = 1'b1; fixed_pat = {64{8'hA5}}; log_q.delete();
    start_job(64'h1000, 64'h2000, 1);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (op !== exp_ops[i]) begin $display("FAIL single_op_seq[%0d]: got %b required %b", i, op, exp_ops[i]); miscompares++; end
      tick();
    end
    vectors += 5;
    if (done !== 1'b1) begin $display("FAIL single_done: got %b required 1", done); miscompares++; end
    if (lines_done !== 43'd1) begin $display("FAIL single_lines_done: got %0d required 1", lines_done); miscompares++; end
    if (log_q.size() != 2) begin $display("FAIL single_req_count: got %0d required 2", log_q.size()); miscompares++; end
    else begin
      if (log_q[0].addr !== 64'h1000) begin $display("FAIL single_rd_addr: got %h required 1000", log_q[0].addr); miscompares++; end
      if (log_q[1].addr !== 64'h2000 || log_q[1].data !== {64{8'hA5}}) begin
        $display("FAIL single_write: addr %h data %h required 2000 / a5..", log_q[1].addr, log_q[1].data); miscompares++;
      end
    end
    use_pat = 1'b0;
  endtask

  task automatic test_zero_length();
    log_q.delete();
    start_job(64'h5000, 64'h6000, 0);
    vectors++;
    if (op !== 2'b00) begin $display("FAIL zero_op_c1: got %b required 00", op); miscompares++; end
    tick();
    vectors += 5;
    if (done !== 1'b1) begin $display("FAIL zero_done: got %b required 1", done); miscompares++; end
    if (op !== 2'b00) begin $display("FAIL zero_op_c2: got %b required 00", op); miscompares++; end
    if (busy !== 1'b0) begin $display("FAIL zero_busy: got %b required 0", busy); miscompares++; end
    if (lines_done !== '0) begin $display("FAIL zero_lines_done: got %0d required 0", lines_done); miscompares++; end
    if (log_q.size() != 0) begin $display("FAIL zero_req_count: got %0d required 0", log_q.size()); miscompares++; end
  endtask

  task automatic test_unaligned();
    logic [AW-1:0] ra, wa;
    lat = 1; log_q.delete();
    start_job(64'h1013, 64'h2027, 3);
    wait_done("unaligned", 100);
    vectors += 2;
    if (lines_done !== 43'd3) begin $display("FAIL unaligned_lines_done: got %0d required 3", lines_done); miscompares++; end
    if (log_q.size() != 6) begin $display("FAIL unaligned_req_count: got %0d required 6", log_q.size()); miscompares++; end
    else begin
      for (int i = 0; i < 3; i++) begin
        ra = 64'h1000 + 64'(i * 64);
        wa = 64'h2000 + 64'(i * 64);
        vectors += 3;
        if (log_q[2*i].op !== 2'b01 || log_q[2*i].addr !== ra) begin
          $display("FAIL unaligned_rd[%0d]: op %b addr %h required 01 %h", i, log_q[2*i].op, log_q[2*i].addr, ra); miscompares++;
        end
        if (log_q[2*i+1].op !== 2'b10 || log_q[2*i+1].addr !== wa) begin
          $display("FAIL unaligned_wr[%0d]: op %b addr %h required 10 %h", i, log_q[2*i+1].op, log_q[2*i+1].addr, wa); miscompares++;
        end
        if (log_q[2*i+1].data !== {8{ra}}) begin
          $display("FAIL unaligned_wr_data[%0d]: got %h required %h", i, log_q[2*i+1].data[63:0], ra); miscompares++;
        end
      end
    end
  endtask

  task automatic test_wrap_and_start_abort();
    lat = 0; log_q.delete();
    abort = 1'b1;
    start_job(64'hFFFF_FFFF_FFFF_FFC5, 64'h0000_0000_0000_0010, 2);
    abort = 1'b0;
    wait_done("wrap", 100);
    vectors += 2;
    if (lines_done !== 43'd2) begin $display("FAIL wrap_lines_done: got %0d required 2", lines_done); miscompares++; end
    if (log_q.size() != 4) begin $display("FAIL wrap_req_count: got %0d required 4", log_q.size()); miscompares++; end
    else begin
      vectors += 2;
      if (log_q[0].addr !== 64'hFFFF_FFFF_FFFF_FFC0) begin $display("FAIL wrap_rd0: got %h required ffffffffffffffc0", log_q[0].addr); miscompares++; end
      if (log_q[2].addr !== 64'h0 || log_q[3].addr !== 64'h40) begin
        $display("FAIL wrap_line1: rd %h wr %h required 0 / 40", log_q[2].addr, log_q[3].addr); miscompares++;
      end
    end
  endtask

  task automatic test_abort();
    bit hit = 0;
    lat = 2; log_q.delete();
    start_job(64'h3000, 64'h4000, 8);
    for (int i = 0; i < 200 && !hit; i++) begin
      if (op == 2'b01 && log_q.size() == 6) hit = 1; else tick();
    end
    vectors++;
    if (!hit) begin $display("FAIL abort_reach_line3: not reached, lines_done %0d", lines_done); miscompares++; end
    abort = 1'b1; tick(); abort = 1'b0;
    wait_done("abort", 100);
    tick(); tick();
    vectors += 3;
    if (lines_done !== 43'd3) begin $display("FAIL abort_lines_done: got %0d required 3", lines_done); miscompares++; end
    if (op !== 2'b00) begin $display("FAIL abort_op_idle: got %b required 00", op); miscompares++; end
    if (log_q.size() != 7) begin $display("FAIL abort_req_count: got %0d required 7", log_q.size()); miscompares++; end
    else begin
      vectors++;
      if (log_q[6].op !== 2'b01 || log_q[6].addr !== 64'h30C0) begin
        $display("FAIL abort_last_req: op %b addr %h required 01 30c0", log_q[6].op, log_q[6].addr); miscompares++;
      end
    end
  endtask

  task automatic test_start_while_busy();
    lat = 1; log_q.delete();
    start_job(64'h8000, 64'h9000, 4);
    tick(); tick(); tick();
    start_job(64'hA000, 64'hB000, 5);
    wait_done("busy_start", 200);
    vectors += 3;
    if (lines_done !== 43'd4) begin $display("FAIL busy_start_lines_done: got %0d required 4", lines_done); miscompares++; end
    if (log_q.size() != 8) begin $display("FAIL busy_start_req_count: got %0d required 8", log_q.size()); miscompares++; end
    if (log_q.size() == 8 && log_q[7].addr !== 64'h90C0) begin
      $display("FAIL busy_start_last_wr: got %h required 90c0", log_q[7].addr); miscompares++;
    end
  endtask

  task automatic test_delayed();
    lat = 10; log_q.delete(); stab_err = 0;
    start_job(64'hC000, 64'hD000, 2);
    wait_done("delayed", 300);
    vectors += 3;
    if (stab_err != 0) begin $display("FAIL delayed_stability: %0d unstable cycles, required 0", stab_err); miscompares++; end
    if (log_q.size() != 4) begin $display("FAIL delayed_req_count: got %0d required 4", log_q.size()); miscompares++; end
    if (lines_done !== 43'd2) begin $display("FAIL delayed_lines_done: got %0d required 2", lines_done); miscompares++; end
`ifdef XFER_PERF_CNT_EN
    tick(); tick(); tick();
    vectors++;
    if (perf_cycles !== 32'd48) begin $display("FAIL delayed_perf: got %0d required 48", perf_cycles); miscompares++; end
`endif
  endtask

  task automatic test_reset_mid_write();
    bit hit = 0;
    lat = 10;
    start_job(64'hE000, 64'hF000, 4);
    for (int i = 0; i < 200 && !hit; i++) begin
      if (op == 2'b10) hit = 1; else tick();
    end
    vectors++;
    if (!hit) begin $display("FAIL rstmid_reach_write: op %b", op); miscompares++; end
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    vectors += 6;
    if (op !== 2'b00) begin $display("FAIL rstmid_op: got %b required 00", op); miscompares++; end
    if (raw_address !== '0) begin $display("FAIL rstmid_addr: got %h required 0", raw_address); miscompares++; end
    if (wr_data !== '0) begin $display("FAIL rstmid_wr_data: got %h required 0", wr_data); miscompares++; end
    if (busy !== 1'b0) begin $display("FAIL rstmid_busy: got %b required 0", busy); miscompares++; end
    if (done !== 1'b0) begin $display("FAIL rstmid_done: got %b required 0", done); miscompares++; end
    if (lines_done !== '0) begin $display("FAIL rstmid_lines_done: got %0d required 0", lines_done); miscompares++; end
`ifdef XFER_PERF_CNT_EN
    vectors++;
    if (perf_cycles !== 32'd0) begin $display("FAIL rstmid_perf: got %0d required 0", perf_cycles); miscompares++; end
`endif
    tick(); tick(); tick();
    vectors++;
    if (op !== 2'b00 || busy !== 1'b0) begin $display("FAIL rstmid_stays_idle: op %b busy %b required 00 0", op, busy); miscompares++; end
    lat = 0;
    start_job(64'h100, 64'h200, 1);
    wait_done("post_reset", 50);
    vectors++;
    if (lines_done !== 43'd1) begin $display("FAIL post_reset_lines_done: got %0d required 1", lines_done); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_zero_length();
    test_unaligned();
    test_wrap_and_start_abort();
    test_abort();
    test_start_while_busy();
    test_delayed();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
